// File: rtl/io_bus_pkg.sv
// Shared definitions for the CPU-side I/O port bus.
// Any master that arbitrates for the port bus imports this package.
package io_bus_pkg;

  localparam int DIR_W  = 5;
  localparam int DATA_W = 16;

  localparam logic [DIR_W-1:0] IDLE_DIR = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick.
// On a tie, the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_winner;
    end else begin
      winner = req1;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the CPU-side I/O port bus between the core (m0)
// and a secondary master (m1). Each grant runs one fixed-length bus transaction.
module io_bus_arbiter #(
  parameter int DIR_W         = io_bus_pkg::DIR_W,
  parameter int DATA_W        = io_bus_pkg::DATA_W,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [DIR_W-1:0]  m0_dir,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [DIR_W-1:0]  m1_dir,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [DIR_W-1:0]  dirport,
  output logic [DATA_W-1:0] outport,
  output logic              we,
  input  logic [DATA_W-1:0] inport
);

  import io_bus_pkg::*;

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("io_bus_arbiter: ACCESS_CYCLES must be in the range 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_winner_q, last_winner_d;
  logic [DIR_W-1:0]    dirport_q, dirport_d;
  logic [DATA_W-1:0]   outport_q, outport_d;
  logic                we_q, we_d;
  logic                m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic                m0_done_q, m0_done_d, m1_done_q, m1_done_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic pick_winner;
  logic pick_valid;

  rr_arbiter2 u_rr_arbiter2 (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_winner (last_winner_q),
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  // last_winner_q doubles as the owner of the transaction in flight.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_winner_d = last_winner_q;
    dirport_d     = dirport_q;
    outport_d     = outport_q;
    we_d          = we_q;
    m0_gnt_d      = m0_gnt_q;
    m1_gnt_d      = m1_gnt_q;
    m0_done_d     = 1'b0;
    m1_done_d     = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;

    case (state_q)
      IDLE: begin
        dirport_d = DIR_W'(IDLE_DIR);
        outport_d = '0;
        we_d      = 1'b0;
        if (pick_valid) begin
          dirport_d     = pick_winner ? m1_dir   : m0_dir;
          outport_d     = pick_winner ? m1_wdata : m0_wdata;
          we_d          = pick_winner ? m1_we    : m0_we;
          m0_gnt_d      = ~pick_winner;
          m1_gnt_d      = pick_winner;
          last_winner_d = pick_winner;
          cnt_d         = CNT_LOAD;
          state_d       = ACCESS;
        end
      end

      ACCESS: begin
        // The write strobe lives only in the first access cycle: one device write per grant.
        we_d = 1'b0;
        if (cnt_q == 4'd0) begin
          if (last_winner_q) begin
            m1_rdata_d = inport;
            m1_done_d  = 1'b1;
          end else begin
            m0_rdata_d = inport;
            m0_done_d  = 1'b1;
          end
          m0_gnt_d  = 1'b0;
          m1_gnt_d  = 1'b0;
          dirport_d = DIR_W'(IDLE_DIR);
          outport_d = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      last_winner_q <= 1'b1;
      dirport_q     <= '0;
      outport_q     <= '0;
      we_q          <= 1'b0;
      m0_gnt_q      <= 1'b0;
      m1_gnt_q      <= 1'b0;
      m0_done_q     <= 1'b0;
      m1_done_q     <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_winner_q <= last_winner_d;
      dirport_q     <= dirport_d;
      outport_q     <= outport_d;
      we_q          <= we_d;
      m0_gnt_q      <= m0_gnt_d;
      m1_gnt_q      <= m1_gnt_d;
      m0_done_q     <= m0_done_d;
      m1_done_q     <= m1_done_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

  assign dirport  = dirport_q;
  assign outport  = outport_q;
  assign we       = we_q;
  assign m0_gnt   = m0_gnt_q;
  assign m1_gnt   = m1_gnt_q;
  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: a 1-cycle instance on a register-file bus model,
// plus a 4-cycle instance for the long-access timing.
module tb_io_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m0_req, m1_req, m0_we, m1_we;
    logic [4:0]  m0_dir, m1_dir;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_done, m1_done;
    logic [15:0] m0_rdata, m1_rdata;
    logic [4:0]  dirport;
    logic [15:0] outport, inport;
    logic        we;

    logic        d4_m0_req, d4_m1_req, d4_m0_we, d4_m1_we;
    logic [4:0]  d4_m0_dir, d4_m1_dir;
    logic [15:0] d4_m0_wdata, d4_m1_wdata;
    logic        d4_m0_gnt, d4_m1_gnt, d4_m0_done, d4_m1_done;
    logic [15:0] d4_m0_rdata, d4_m1_rdata;
    logic [4:0]  d4_dirport;
    logic [15:0] d4_outport, d4_inport;
    logic        d4_we;

    io_bus_arbiter #(.DIR_W(5), .DATA_W(16), .ACCESS_CYCLES(1)) dut (
        .clk(clk), .reset(rst),
        .m0_req(m0_req), .m0_dir(m0_dir), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_dir(m1_dir), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .dirport(dirport), .outport(outport), .we(we), .inport(inport)
    );

    io_bus_arbiter #(.DIR_W(5), .DATA_W(16), .ACCESS_CYCLES(4)) dut4 (
        .clk(clk), .reset(rst),
        .m0_req(d4_m0_req), .m0_dir(d4_m0_dir), .m0_wdata(d4_m0_wdata), .m0_we(d4_m0_we),
        .m0_gnt(d4_m0_gnt), .m0_done(d4_m0_done), .m0_rdata(d4_m0_rdata),
        .m1_req(d4_m1_req), .m1_dir(d4_m1_dir), .m1_wdata(d4_m1_wdata), .m1_we(d4_m1_we),
        .m1_gnt(d4_m1_gnt), .m1_done(d4_m1_done), .m1_rdata(d4_m1_rdata),
        .dirport(d4_dirport), .outport(d4_outport), .we(d4_we), .inport(d4_inport)
    );

    logic [15:0] dev_regs [32];
    logic [7:0]  led;
    assign inport = dev_regs[dirport];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) dev_regs[i] <= 16'h0000;
            led <= 8'h00;
        end else if (we) begin
            dev_regs[dirport] <= outport;
            if (dirport[4:2] == 3'd0) led <= outport[7:0];
        end
    end

    int errors = 0;
    int checks = 0;

    int          exp_last;
    logic [15:0] exp_rd [2];
    bit          rd_known [2];
    int          txn_no = 0;

    task automatic model_reset();
        exp_last    = 1;
        exp_rd[0]   = 16'h0000;
        exp_rd[1]   = 16'h0000;
        rd_known[0] = 1'b1;
        rd_known[1] = 1'b1;
    endtask

    task automatic txn(input bit r0, input bit r1,
                       input logic [4:0] d0, input logic [4:0] d1,
                       input logic [15:0] w0, input logic [15:0] w1,
                       input bit we0, input bit we1, input bit drop,
                       output int obs);
        int          win;
        logic [4:0]  ed;
        logic [15:0] ew, exp_val, got_rd, oth_rd;
        bit          ewr;
        m0_req = r0; m0_dir = d0; m0_wdata = w0; m0_we = we0;
        m1_req = r1; m1_dir = d1; m1_wdata = w1; m1_we = we1;
        if (r0 && r1) win = (exp_last == 0) ? 1 : 0;
        else          win = r1 ? 1 : 0;
        ed  = win ? d1 : d0;
        ew  = win ? w1 : w0;
        ewr = win ? we1 : we0;
        exp_val = dev_regs[ed];
        txn_no++;

        @(negedge clk);
        obs = (m0_gnt && m1_gnt) ? 2 : (m1_gnt ? 1 : (m0_gnt ? 0 : -1));
        checks++;
        if (obs != win) begin
            errors++;
            $display("FAIL grant: txn %0d got owner %0d expected %0d", txn_no, obs, win);
        end
        checks++;
        if ({dirport, outport, we} !== {ed, ew, ewr}) begin
            errors++;
            $display("FAIL bus_drive: txn %0d got dir=%h data=%h we=%b expected dir=%h data=%h we=%b",
                     txn_no, dirport, outport, we, ed, ew, ewr);
        end
        checks++;
        if ({m0_done, m1_done} !== 2'b00) begin
            errors++;
            $display("FAIL early_done: txn %0d got done=%b%b expected 00", txn_no, m1_done, m0_done);
        end
        if (drop) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
        end

        @(negedge clk);
        checks++;
        if ({m1_done, m0_done} !== (win ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL done_pulse: txn %0d got done=%b%b expected winner m%0d", txn_no, m1_done, m0_done, win);
        end
        checks++;
        if ({m0_gnt, m1_gnt, we, dirport, outport} !== 24'h0) begin
            errors++;
            $display("FAIL bus_release: txn %0d got gnt=%b%b we=%b dir=%h data=%h expected all 0",
                     txn_no, m1_gnt, m0_gnt, we, dirport, outport);
        end
        if (!ewr) begin
            exp_rd[win]   = exp_val;
            rd_known[win] = 1'b1;
        end else begin
            rd_known[win] = 1'b0;
        end
        got_rd = win ? m1_rdata : m0_rdata;
        oth_rd = win ? m0_rdata : m1_rdata;
        if (rd_known[win]) begin
            checks++;
            if (got_rd !== exp_rd[win]) begin
                errors++;
                $display("FAIL rdata: txn %0d m%0d got %h expected %h", txn_no, win, got_rd, exp_rd[win]);
            end
        end
        if (rd_known[1-win]) begin
            checks++;
            if (oth_rd !== exp_rd[1-win]) begin
                errors++;
                $display("FAIL loser_rdata: txn %0d m%0d got %h expected %h", txn_no, 1-win, oth_rd, exp_rd[1-win]);
            end
        end
        exp_last = win;
        $display("txn %0d: req=%b%b winner=m%0d dir=%h data=%h we=%b", txn_no, r1, r0, win, ed, ew, ewr);

        @(negedge clk);
        checks++;
        if ({m0_done, m1_done, m0_gnt, m1_gnt, we} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_done: txn %0d got done=%b%b gnt=%b%b we=%b expected 0",
                     txn_no, m1_done, m0_done, m1_gnt, m0_gnt, we);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {m0_req, m1_req, m0_we, m1_we} = 4'b0;
        m0_dir = '0; m1_dir = '0; m0_wdata = '0; m1_wdata = '0;
        {d4_m0_req, d4_m1_req, d4_m0_we, d4_m1_we} = 4'b0;
        d4_m0_dir = '0; d4_m1_dir = '0; d4_m0_wdata = '0; d4_m1_wdata = '0;
        d4_inport = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done, we, dirport, outport, m0_rdata, m1_rdata} !== 58'h0) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b%b done=%b%b we=%b dir=%h data=%h rd0=%h rd1=%h expected all 0",
                     m1_gnt, m0_gnt, m1_done, m0_done, we, dirport, outport, m0_rdata, m1_rdata);
        end
        checks++;
        if ({d4_m0_gnt, d4_m1_gnt, d4_m0_done, d4_m1_done, d4_we, d4_dirport, d4_outport} !== 26'h0) begin
            errors++;
            $display("FAIL reset_state4: got gnt=%b%b done=%b%b we=%b expected all 0",
                     d4_m1_gnt, d4_m0_gnt, d4_m1_done, d4_m0_done, d4_we);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done, we, dirport, outport} !== 26'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got gnt=%b%b done=%b%b we=%b expected all 0",
                     m1_gnt, m0_gnt, m1_done, m0_done, we);
        end
    endtask

    task automatic test_m0_write();
        int obs;
        txn(1'b1, 1'b0, 5'b00000, 5'b00000, 16'h00A5, 16'h0000, 1'b1, 1'b0, 1'b0, obs);
        checks++;
        if (led !== 8'hA5) begin
            errors++;
            $display("FAIL led_readback: got %h expected a5", led);
        end
    endtask

    task automatic test_m1_read();
        int obs;
        txn(1'b0, 1'b1, 5'b00000, 5'b00100, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0, obs);
        txn(1'b1, 1'b0, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, obs);
        txn(1'b0, 1'b1, 5'b00000, 5'b00100, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, obs);
        checks++;
        if (m1_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL m1_read: got %h expected 1234", m1_rdata);
        end
        checks++;
        if (m0_rdata !== 16'h00A5) begin
            errors++;
            $display("FAIL m0_rdata_kept: got %h expected 00a5", m0_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int obs;
        for (int i = 0; i < 6; i++) begin
            txn(1'b1, 1'b1, 5'(i), 5'(i + 8), 16'(i), 16'(i + 100), 1'b0, 1'b0, 1'b0, obs);
            checks++;
            if (obs != (i % 2)) begin
                errors++;
                $display("FAIL alternation: slot %0d got m%0d expected m%0d", i, obs, i % 2);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_long_access();
        int          wcount = 0;
        logic [15:0] rv;
        d4_m0_dir = 5'h09; d4_m0_wdata = 16'hBEEF; d4_m0_we = 1'b1; d4_m0_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (d4_we) wcount++;
            checks++;
            if ({d4_m0_gnt, d4_m1_gnt, d4_dirport, d4_outport, d4_we, d4_m0_done} !== {2'b10, 5'h09, 16'hBEEF, (k == 1), 1'b0}) begin
                errors++;
                $display("FAIL long_hold: cycle %0d got gnt=%b%b dir=%h data=%h we=%b done=%b expected m0 09 beef we=%0d",
                         k, d4_m1_gnt, d4_m0_gnt, d4_dirport, d4_outport, d4_we, d4_m0_done, (k == 1));
            end
            d4_m0_dir = 5'h1F; d4_m0_wdata = 16'h0000;
        end
        @(negedge clk);
        checks++;
        if ({d4_m0_done, d4_m1_done, d4_m0_gnt, d4_we, d4_dirport} !== {2'b10, 1'b0, 1'b0, 5'h00}) begin
            errors++;
            $display("FAIL long_done: got done=%b%b gnt=%b we=%b dir=%h expected done on m0 at N+5",
                     d4_m1_done, d4_m0_done, d4_m0_gnt, d4_we, d4_dirport);
        end
        checks++;
        if (wcount != 1) begin
            errors++;
            $display("FAIL long_write_count: got %0d expected 1", wcount);
        end
        $display("txn long write: dir=09 data=beef write_cycles=%0d", wcount);
        d4_m0_req = 1'b0;
        @(negedge clk);
        rv = 16'($urandom);
        d4_inport = rv;
        d4_m0_dir = 5'h03; d4_m0_we = 1'b0; d4_m0_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({d4_m0_done, d4_m1_done} !== 2'b00) begin
                errors++;
                $display("FAIL long_early_done: got done=%b%b", d4_m1_done, d4_m0_done);
            end
        end
        @(negedge clk);
        checks++;
        if (d4_m0_done !== 1'b1 || d4_m0_rdata !== rv) begin
            errors++;
            $display("FAIL long_read: got done=%b rdata=%h expected done=1 rdata=%h", d4_m0_done, d4_m0_rdata, rv);
        end
        checks++;
        if (d4_m1_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL long_m1_rdata: got %h expected 0000", d4_m1_rdata);
        end
        $display("txn long read: dir=03 rdata=%h", d4_m0_rdata);
        d4_m0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        int obs;
        txn(1'b1, 1'b0, 5'h10, 5'h00, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, obs);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, m0_done, m1_done, we} !== 5'b0) begin
                errors++;
                $display("FAIL drop_no_regrant: got gnt=%b%b done=%b%b we=%b expected 0", m1_gnt, m0_gnt, m1_done, m0_done, we);
            end
        end
    endtask

    task automatic test_random();
        int         obs;
        logic [1:0] r;
        for (int i = 0; i < 24; i++) begin
            r = 2'($urandom_range(1, 3));
            txn(r[0], r[1], 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), 1'b0, obs);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int obs;
        m0_req = 1'b1; m0_dir = 5'h08; m0_wdata = 16'hCAFE; m0_we = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (we !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_we: got %b expected 1", we);
        end
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        checks++;
        if ({we, m0_gnt, m1_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got we=%b gnt=%b%b expected 0", we, m1_gnt, m0_gnt);
        end
        model_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({m0_done, m1_done, m0_gnt, m1_gnt, we} !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold: got done=%b%b gnt=%b%b we=%b expected 0", m1_done, m0_done, m1_gnt, m0_gnt, we);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_done, m1_done, m0_rdata, m1_rdata} !== 34'h0) begin
            errors++;
            $display("FAIL post_reset: got done=%b%b rd0=%h rd1=%h expected 0", m1_done, m0_done, m0_rdata, m1_rdata);
        end
        txn(1'b1, 1'b1, 5'h01, 5'h02, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, obs);
        checks++;
        if (obs != 0) begin
            errors++;
            $display("FAIL first_tie_after_reset: got m%0d expected m0", obs);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read();
        test_back_to_back();
        test_long_access();
        test_drop_req();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single CPU-side I/O port bus between two requesters: requester 0 is the processor core and requester 1 is a secondary master such as a DMA or debug engine.
- The shared bus is the 5-bit port address, 16-bit write data, write enable and 16-bit read data that feed the I/O decode logic and device controllers.
- Arbitration is round-robin. Each transfer is sequenced as one bus transaction of fixed length.
- Read data is returned to the winner with a one-cycle done pulse.

Parameters:
- DIR_W, 5: port address width; bits [4:2] select the device, bits [1:0] select the register.
- DATA_W, 16: data width.
- ACCESS_CYCLES, 1: number of cycles the bus is held per transaction. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 transaction request; held until m0_done.
- m0_dir  in  DIR_W  requester 0 port address; stable while m0_req is high.
- m0_wdata  in  DATA_W  requester 0 write data.
- m0_we  in  1  requester 0 write (1) or read (0).
- m0_gnt  out  1  requester 0 owns the bus.
- m0_done  out  1  one-cycle pulse: requester 0 transaction complete.
- m0_rdata  out  DATA_W  requester 0 read data; valid while m0_done is high and held afterwards.
- m1_req, m1_dir, m1_wdata, m1_we, m1_gnt, m1_done, m1_rdata: same definitions for requester 1.
- dirport  out  DIR_W  shared bus address.
- outport  out  DATA_W  shared bus write data.
- we  out  1  shared bus write strobe.
- inport  in  DATA_W  shared bus read data from the I/O decode logic.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE.
  - dirport = 0, outport = 0, we = 0.
  - gnt, done and rdata = 0 for both requesters.
  - last_winner = 1, so requester 0 wins the first tie.
  - Access counter = 0.
- All bus outputs are registered. No combinational path exists from req inputs to the bus.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Bus is idle: dirport = 0, outport = 0, we = 0.
  - If no request is pending, remain in IDLE.
  - If only one req is high, that requester wins.
  - If both are high, the winner is the requester that is not last_winner.
  - On the winning edge: register the winner's dir/wdata onto dirport/outport and its we onto the bus write strobe, set the winner's gnt, update last_winner, load the counter with ACCESS_CYCLES-1, and go to ACCESS.
- ACCESS:
  - Bus fields are held constant.
  - we is high only in the first ACCESS cycle, if the winner's we was 1. This gives exactly one device write per transaction, regardless of ACCESS_CYCLES.
  - The counter decrements each cycle.
  - In the cycle where the counter = 0: capture inport into the winner's rdata (for writes too; the value is don't-care), clear gnt, return the bus to idle values, pulse the winner's done, and go to DONE.
- DONE:
  - The done pulse is high for this single cycle, then the state returns to IDLE.
  - Arbitration is not evaluated in DONE. A req still high in the cycle after done is treated as a new request.
- Latency: request seen in IDLE at edge N.
  - Bus driven for cycles N+1 .. N+ACCESS_CYCLES.
  - done high in cycle N+ACCESS_CYCLES+1.
  - Minimum back-to-back period is ACCESS_CYCLES+2 cycles.
- Boundary conditions:
  - Requester drops req during ACCESS: the transaction completes anyway and done still pulses. Aborting is not supported.
  - The losing requester keeps its req high: it is served in the next IDLE. Starvation is impossible under continuous contention (strict alternation).
  - Requester changes dir/wdata during its own ACCESS: no effect, because bus values were latched at grant.
  - gnt is never high for both requesters. done is never high for both requesters.
  - The rdata of the non-winning requester is never modified.
  - Reset asserted mid-ACCESS: we drops immediately, and no done is produced.
  - ACCESS_CYCLES outside 1..15: elaboration error.

Decomposition:
- Shared package io_bus_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - DIR_W = 5 and DATA_W = 16 constants;
  - IDLE_DIR = 0.
  - Reused by future bus masters.
- One sub-module, rr_arbiter2: a combinational two-way round-robin pick from {req0, req1, last_winner}. Outputs are winner and valid.

Test Plan:
- Reset then idle: all outputs 0 and the bus idle. Assert reset for 3 cycles mid-run -> we = 0 on the same cycle as reset, and no done.
- m0 write only (dir = 5'b00000, wdata = 16'h00A5, we = 1, ACCESS_CYCLES = 1):
  - dirport = 0 and outport = 16'h00A5 with we = 1 for exactly one cycle;
  - m0_done pulses 2 cycles after the request edge;
  - the LED device reads back 8'hA5.
- m1 read of dir = 5'b00100 with the bus model returning 16'h1234 -> m1_rdata = 16'h1234 when m1_done pulses; m0_rdata is unchanged.
- Both requesters held high for 6 transactions -> grant order 0,1,0,1,0,1, and never both gnt high.
- ACCESS_CYCLES = 4, m0 write -> bus held for 4 cycles, we high only in the first of them, done at cycle N+5.
- m0 drops req during ACCESS -> transaction completes, m0_done pulses once, then the FSM returns to IDLE with no new grant.
